// File: rtl/fht_rd_pkg.sv
// Shared types and helpers for the FHT result-RAM unloader.
// Holds the unloader FSM state enum, the row bit-reversal helper and the
// normalisation shift offset used when FHT_UNLOAD_NORM_EN is defined.
package fht_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } rd_state_t;

    // log2 of the bank count; the normalisation shift is A_BIT + NORM_SHIFT,
    // i.e. log2 of the full transform length.
    localparam int NORM_SHIFT = 2;

    // Widest row address the bit-reversal helper handles.
    localparam int MAX_A_BIT = 16;

    // Reverse the low a_bit bits of val; bits above a_bit come back as zero.
    function automatic logic [MAX_A_BIT-1:0] f_bit_rev(
        input logic [MAX_A_BIT-1:0] val,
        input int                   a_bit
    );
        logic [MAX_A_BIT-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_A_BIT; i++) begin
            if (i < a_bit) begin
                res[a_bit-1-i] = val[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fht_rd_line_buf.sv
// Purpose: two-entry ping-pong row buffer (4 words + row tag per entry) between RAM fetch and stream.
// Latency: fill visible on rd_* the cycle after fill_vld; reserve/free take effect next cycle.
// Backpressure: none internally; the owner issues a fetch only when rsv_busy shows the target entry free.
//
// Ports: core_clk/arst_n clock and async active-low reset; rsv_* reserves an entry when a fetch
// is issued; fill_* writes the four bank words and row tag; free_* releases an entry after its
// last word is streamed; rd_* selects entry and bank for the stream side.
module fht_rd_line_buf
    import fht_rd_pkg::*;
#(
    parameter int D_BIT = 22,
    parameter int A_BIT = 8
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  rsv_vld,
    input  logic                  rsv_sel,
    input  logic                  fill_vld,
    input  logic                  fill_sel,
    input  logic [A_BIT-1:0]      fill_tag,
    input  logic [3:0][D_BIT-1:0] fill_dat,
    input  logic                  free_vld,
    input  logic                  free_sel,
    output logic [1:0]            rsv_busy,
    input  logic                  rd_sel,
    input  logic [1:0]            rd_bank,
    output logic                  rd_full,
    output logic [D_BIT-1:0]      rd_dat,
    output logic [A_BIT-1:0]      rd_tag
);

    // rsv_q: entry owned by an in-flight fetch or holding data.
    // full_q: entry holds a complete row ready to stream.
    logic [1:0]                   rsv_q;
    logic [1:0]                   full_q;
    logic [1:0][3:0][D_BIT-1:0]   word_q;
    logic [1:0][A_BIT-1:0]        tag_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            rsv_q  <= '0;
            full_q <= '0;
            word_q <= '0;
            tag_q  <= '0;
        end else begin
            for (int e = 0; e < 2; e++) begin
                // Free first so a same-cycle re-reservation of the entry wins.
                if (free_vld && (free_sel == 1'(e))) begin
                    rsv_q[e]  <= 1'b0;
                    full_q[e] <= 1'b0;
                end
                if (rsv_vld && (rsv_sel == 1'(e))) begin
                    rsv_q[e] <= 1'b1;
                end
                if (fill_vld && (fill_sel == 1'(e))) begin
                    full_q[e] <= 1'b1;
                    word_q[e] <= fill_dat;
                    tag_q[e]  <= fill_tag;
                end
            end
        end
    end

    assign rsv_busy = rsv_q;
    assign rd_full  = full_q[rd_sel];
    assign rd_dat   = word_q[rd_sel][rd_bank];
    assign rd_tag   = tag_q[rd_sel];

endmodule

// File: rtl/fht_rd_unload.sv
// Purpose: unload the four FHT result banks row by row and stream samples in natural order.
// Latency: start at edge 0, row-0 address after edge 1, first oVALID after edge RAM_LAT+2 (+1 with FHT_UNLOAD_NORM_EN).
// Backpressure: valid/ready; outputs hold while iREADY=0, fetches stall once both line buffers are owned.
//
// Ports: iCLK/iRESET (async, active low); iSTART/iBIT_REV start an unload; oADDR_RD_0..3 drive
// the bank read addresses (all equal); iDATA_0..3 return bank words RAM_LAT cycles later;
// oDATA/oINDEX/oVALID/iREADY/oLAST form the sample stream; oBUSY while unloading; oDONE pulses
// after the final beat is accepted.
// Option: define FHT_UNLOAD_NORM_EN to divide samples by N (round half up, saturating) through
// one extra output register stage.
module fht_rd_unload
    import fht_rd_pkg::*;
#(
    parameter int D_BIT   = 22,
    parameter int A_BIT   = 8,
    parameter int RAM_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iBIT_REV,
    output logic [A_BIT-1:0]   oADDR_RD_0,
    output logic [A_BIT-1:0]   oADDR_RD_1,
    output logic [A_BIT-1:0]   oADDR_RD_2,
    output logic [A_BIT-1:0]   oADDR_RD_3,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic [A_BIT+1:0]   oINDEX,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oLAST,
    output logic               oBUSY,
    output logic               oDONE
);

    rd_state_t state_q, state_d;

    logic                 bit_rev_q;
    logic                 busy_q;
    logic                 done_q;
    logic [A_BIT-1:0]     fetch_row_q;
    logic [A_BIT-1:0]     addr_q;

    // Fetch tracking pipe: stage RAM_LAT marks the cycle in which iDATA_x
    // belongs to the row issued RAM_LAT+1 edges earlier.
    logic [RAM_LAT:0]             pipe_vld_q;
    logic [RAM_LAT:0][A_BIT-1:0]  pipe_row_q;

    // Stream side: which ping-pong entry and which bank word is presented.
    logic                 str_sel_q;
    logic [1:0]           str_bank_q;

    logic [1:0]           rsv_busy;
    logic                 rd_full;
    logic [D_BIT-1:0]     rd_dat;
    logic [A_BIT-1:0]     rd_tag;

    logic                 issue_sel;
    logic                 buf_avail;
    logic                 issue;
    logic                 last_row;
    logic                 st_vld;
    logic                 st_rdy;
    logic                 st_xfer;
    logic                 st_last;
    logic                 free_vld;
    logic                 last_acc;
    logic [A_BIT-1:0]     addr_nxt;

    // Rows alternate between the two entries, so row parity selects the entry.
    assign issue_sel = fetch_row_q[0];
    assign last_row  = &fetch_row_q;
    assign st_vld    = rd_full;
    assign st_xfer   = st_vld && st_rdy;
    assign st_last   = (&rd_tag) && (str_bank_q == 2'd3);
    assign free_vld  = st_xfer && (str_bank_q == 2'd3);
    // An entry being released this cycle can be re-reserved at the same edge,
    // which keeps the stream free of bubbles.
    assign buf_avail = !rsv_busy[issue_sel] || (free_vld && (str_sel_q == issue_sel));
    assign issue     = (state_q == ST_RUN) && buf_avail;
    assign last_acc  = oVALID && iREADY && oLAST;
    assign addr_nxt  = bit_rev_q ? A_BIT'(f_bit_rev(MAX_A_BIT'(fetch_row_q), A_BIT))
                                 : fetch_row_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (iSTART)             state_d = ST_RUN;
            ST_RUN:   if (issue && last_row)  state_d = ST_DRAIN;
            ST_DRAIN: if (last_acc)           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q     <= ST_IDLE;
            bit_rev_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fetch_row_q <= '0;
            addr_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_row_q  <= '0;
            str_sel_q   <= 1'b0;
            str_bank_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_DRAIN) && last_acc;

            if ((state_q == ST_IDLE) && iSTART) begin
                bit_rev_q   <= iBIT_REV;
                fetch_row_q <= '0;
                str_sel_q   <= 1'b0;
                str_bank_q  <= '0;
            end

            if (issue) begin
                addr_q <= addr_nxt;
                // Counter parks on the final row instead of wrapping.
                if (!last_row) begin
                    fetch_row_q <= fetch_row_q + A_BIT'(1);
                end
            end

            pipe_vld_q[0] <= issue;
            pipe_row_q[0] <= fetch_row_q;
            for (int i = 1; i <= RAM_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
            end

            if (st_xfer) begin
                str_bank_q <= str_bank_q + 2'd1;
                if (str_bank_q == 2'd3) begin
                    str_sel_q <= ~str_sel_q;
                end
            end
        end
    end

    fht_rd_line_buf #(
        .D_BIT (D_BIT),
        .A_BIT (A_BIT)
    ) u_line_buf (
        .core_clk (iCLK),
        .arst_n   (iRESET),
        .rsv_vld  (issue),
        .rsv_sel  (issue_sel),
        .fill_vld (pipe_vld_q[RAM_LAT]),
        .fill_sel (pipe_row_q[RAM_LAT][0]),
        .fill_tag (pipe_row_q[RAM_LAT]),
        .fill_dat ({iDATA_3, iDATA_2, iDATA_1, iDATA_0}),
        .free_vld (free_vld),
        .free_sel (str_sel_q),
        .rsv_busy (rsv_busy),
        .rd_sel   (str_sel_q),
        .rd_bank  (str_bank_q),
        .rd_full  (rd_full),
        .rd_dat   (rd_dat),
        .rd_tag   (rd_tag)
    );

`ifdef FHT_UNLOAD_NORM_EN
    localparam int S = A_BIT + NORM_SHIFT;
    localparam logic [D_BIT:0] HALF = {{D_BIT{1'b0}}, 1'b1} << (S - 1);

    logic signed [D_BIT:0] norm_sum;
    logic signed [D_BIT:0] norm_shr;
    logic [D_BIT-1:0]      norm_dat;

    logic                  out_vld_q;
    logic [D_BIT-1:0]      out_dat_q;
    logic [A_BIT+1:0]      out_idx_q;
    logic                  out_last_q;

    always_comb begin
        norm_sum = $signed({rd_dat[D_BIT-1], rd_dat}) + $signed(HALF);
        norm_shr = norm_sum >>> S;
        // Top two bits disagreeing means the value left the D_BIT signed range.
        if (norm_shr[D_BIT] != norm_shr[D_BIT-1]) begin
            norm_dat = norm_shr[D_BIT] ? {1'b1, {(D_BIT-1){1'b0}}}
                                       : {1'b0, {(D_BIT-1){1'b1}}};
        end else begin
            norm_dat = norm_shr[D_BIT-1:0];
        end
    end

    assign st_rdy = !out_vld_q || iREADY;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else if (st_rdy) begin
            out_vld_q <= st_vld;
            if (st_vld) begin
                out_dat_q  <= norm_dat;
                out_idx_q  <= {rd_tag, str_bank_q};
                out_last_q <= st_last;
            end
        end
    end

    assign oVALID = out_vld_q;
    assign oDATA  = out_dat_q;
    assign oINDEX = out_idx_q;
    assign oLAST  = out_vld_q && out_last_q;
`else
    assign st_rdy = iREADY;
    assign oVALID = st_vld;
    assign oDATA  = rd_dat;
    assign oINDEX = {rd_tag, str_bank_q};
    assign oLAST  = st_vld && st_last;
`endif

    assign oADDR_RD_0 = addr_q;
    assign oADDR_RD_1 = addr_q;
    assign oADDR_RD_2 = addr_q;
    assign oADDR_RD_3 = addr_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule
